// File: rtl/iob_cache_tg_pkg.sv
// iob_cache_tg_pkg: shared definitions for the IOB cache traffic generator.
// Holds the FSM state encoding, default word geometry and the data pattern.
// No ports; imported by iob_cache_traffic_gen and iob_cache_tg_checker.
package iob_cache_tg_pkg;

  // Default frontend data width and the word geometry it implies.
  localparam int TG_DATA_W = 32;
  localparam int NBYTES    = TG_DATA_W / 8;
  localparam int NBYTES_W  = $clog2(NBYTES);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_GAP       = 3'd2,
    ST_READ_REQ  = 3'd3,
    ST_READ_WAIT = 3'd4,
    ST_DONE      = 3'd5
  } tg_state_t;

  // Data stored at a byte address: mult*addr at full width; callers truncate.
  function automatic logic [63:0] pattern(input logic [63:0] addr, input logic [31:0] mult);
    return addr * {32'd0, mult};
  endfunction

endpackage

// File: rtl/iob_cache_tg_checker.sv
// iob_cache_tg_checker: compares returned read data against the expected word.
// Latency: err_cnt_o/first_err_addr_o update on the edge after rvalid_i; no backpressure.
// Ports: clr_i clears the results; rvalid_i qualifies rdata_i vs exp_i at addr_i.
module iob_cache_tg_checker
  import iob_cache_tg_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = TG_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              rvalid_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [ADDR_W-1:0] first_err_addr_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
    end else if (rvalid_i && (rdata_i != exp_i)) begin
      // Counter saturates so a long failing sweep never wraps back to "pass".
      if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
      if (err_cnt_o == '0) first_err_addr_o <= addr_i;
    end
  end

endmodule

// File: rtl/iob_cache_traffic_gen.sv
// iob_cache_traffic_gen: IOB master that writes mult*addr to N words, idles, reads back and checks.
// Latency: one request per cycle while writing; reads are strictly one outstanding (2-cycle min turnaround).
// Backpressure: holds valid/addr/wdata stable while iob_ready_i is low; start_i ignored while busy_o.
module iob_cache_traffic_gen
  import iob_cache_tg_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = TG_DATA_W,
  parameter int CNT_W      = 8,
  parameter int MULT       = 3,
  parameter int GAP_CYCLES = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [CNT_W-1:0]    nwords_i,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [CNT_W-1:0]    err_cnt_o,
  output logic [ADDR_W-1:0]   first_err_addr_o
);

  localparam int NB    = DATA_W / 8;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  tg_state_t         state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  nwords_q;
  logic [CNT_W-1:0]  idx, idx_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] exp_data;
  logic              last_word;
  logic              start_ok;
  logic              chk_en;
  logic              done_q;
  logic              pass_q;

  assign cur_addr  = base_q + ADDR_W'(idx) * ADDR_W'(NB);
  assign exp_data  = DATA_W'(pattern(64'(cur_addr), 32'(MULT)));
  assign last_word = (idx == nwords_q - CNT_W'(1));
  assign start_ok  = (state == ST_IDLE) && start_i;
  // Responses are only meaningful while a read is outstanding; anything else is stray.
  assign chk_en    = (state == ST_READ_WAIT) && iob_rvalid_i;

  assign busy_o = (state != ST_IDLE);
  assign done_o = done_q;
  assign pass_o = pass_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      base_q   <= '0;
      nwords_q <= '0;
      idx      <= '0;
      gap_cnt  <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      gap_cnt <= gap_nxt;
      done_q  <= (state == ST_DONE);
      if (start_ok) begin
        base_q   <= base_addr_i & ~ADDR_W'(NB - 1);
        nwords_q <= nwords_i;
        pass_q   <= 1'b0;
      end else if (state == ST_DONE) begin
        pass_q <= (err_cnt_o == '0);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    gap_nxt     = gap_cnt;
    iob_valid_o = 1'b0;
    iob_addr_o  = '0;
    iob_wdata_o = '0;
    iob_wstrb_o = '0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          idx_nxt   = '0;
          state_nxt = (nwords_i == '0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        iob_valid_o = 1'b1;
        iob_addr_o  = cur_addr;
        iob_wdata_o = exp_data;
        iob_wstrb_o = '1;
        if (iob_ready_i) begin
          if (last_word) begin
            idx_nxt   = '0;
            gap_nxt   = '0;
            state_nxt = (GAP_CYCLES == 0) ? ST_READ_REQ : ST_GAP;
          end else begin
            idx_nxt = idx + CNT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = ST_READ_REQ;
        else gap_nxt = gap_cnt + GAP_W'(1);
      end
      ST_READ_REQ: begin
        iob_valid_o = 1'b1;
        iob_addr_o  = cur_addr;
        if (iob_ready_i) state_nxt = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        if (iob_rvalid_i) begin
          idx_nxt   = idx + CNT_W'(1);
          state_nxt = last_word ? ST_DONE : ST_READ_REQ;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  iob_cache_tg_checker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_checker (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clr_i           (start_ok),
    .rvalid_i        (chk_en),
    .rdata_i         (iob_rdata_i),
    .exp_i           (exp_data),
    .addr_i          (cur_addr),
    .err_cnt_o       (err_cnt_o),
    .first_err_addr_o(first_err_addr_o)
  );

endmodule

// File: tb/tb_iob_cache_traffic_gen.sv
// tb_iob_cache_traffic_gen: directed bench for iob_cache_traffic_gen with a 1-cycle memory model.
module tb_iob_cache_traffic_gen;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [23:0] base_addr;
  logic [7:0]  nwords;
  logic        iob_valid, iob_ready, iob_rvalid;
  logic [23:0] iob_addr;
  logic [31:0] iob_wdata, iob_rdata;
  logic [3:0]  iob_wstrb;
  logic        busy, done, pass;
  logic [7:0]  err_cnt;
  logic [23:0] first_err_addr;

  always #5 clk = ~clk;

  // memory model state
  logic        m_ready = 1'b1;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        f_rvalid = 1'b0;
  logic [31:0] f_rdata = '0;
  bit          stall_mode = 0, no_resp = 0, corrupt = 0;
  logic [23:0] exp_base = '0;
  int          wr_snap = 0, rd_snap = 0;
  int          wr_cnt = 0, rd_cnt = 0, vld_cycles = 0, sb_err = 0, stall_seen = 0, stall_err = 0;
  bit          pend = 0, acc = 0, stalled = 0;
  logic [23:0] pend_addr, s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  int unsigned stall_cnt = 0;
  logic [31:0] mem [logic [23:0]];

  int nchecks = 0, nerrors = 0;

  assign iob_ready  = m_ready;
  assign iob_rvalid = m_rvalid | f_rvalid;
  assign iob_rdata  = f_rvalid ? f_rdata : m_rdata;

  iob_cache_traffic_gen dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .base_addr_i     (base_addr),
    .nwords_i        (nwords),
    .iob_valid_o     (iob_valid),
    .iob_addr_o      (iob_addr),
    .iob_wdata_o     (iob_wdata),
    .iob_wstrb_o     (iob_wstrb),
    .iob_ready_i     (iob_ready),
    .iob_rvalid_i    (iob_rvalid),
    .iob_rdata_i     (iob_rdata),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .err_cnt_o       (err_cnt),
    .first_err_addr_o(first_err_addr)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hDEAD_BEEF;
  endfunction

  // Request monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [23:0] ea;
    logic [31:0] ed;
    if (stalled && !rst) begin
      if (!(iob_valid && iob_addr == s_addr && iob_wdata == s_wdata && iob_wstrb == s_wstrb))
        stall_err++;
    end
    stalled = 0;
    pend    = 0;
    acc     = 0;
    if (!rst && iob_valid) begin
      vld_cycles++;
      if (!iob_ready) begin
        stalled = 1;
        stall_seen++;
        s_addr  = iob_addr;
        s_wdata = iob_wdata;
        s_wstrb = iob_wstrb;
      end else if (iob_wstrb == 4'hF) begin
        acc = 1;
        ea  = exp_base + 24'(4 * (wr_cnt - wr_snap));
        ed  = 32'd3 * {8'd0, iob_addr};
        if (iob_addr !== ea || iob_wdata !== ed) sb_err++;
        mem[iob_addr] = iob_wdata;
        wr_cnt++;
      end else begin
        acc = 1;
        ea  = exp_base + 24'(4 * (rd_cnt - rd_snap));
        if (iob_addr !== ea || iob_wstrb !== 4'h0) sb_err++;
        rd_cnt++;
        pend      = 1;
        pend_addr = iob_addr;
      end
    end
  end

  // Response and ready generation.
  always @(posedge clk) begin
    int unsigned n;
    m_rvalid <= 1'b0;
    if (pend && !no_resp) begin
      m_rvalid <= 1'b1;
      if (corrupt && pend_addr == 24'd8) m_rdata <= 32'd25;
      else m_rdata <= rd_mem(pend_addr);
    end
    if (!stall_mode) begin
      m_ready   <= 1'b1;
      stall_cnt <= 0;
    end else if (acc) begin
      n = $urandom_range(0, 3);
      stall_cnt <= n;
      m_ready   <= (n == 0);
    end else if (stall_cnt != 0) begin
      stall_cnt <= stall_cnt - 1;
      m_ready   <= (stall_cnt == 1);
    end else begin
      m_ready <= 1'b1;
    end
  end

  int vld_snap, sb_snap, st_snap;

  task automatic start_test(input logic [23:0] b, input logic [7:0] n);
    @(posedge clk); #1;
    exp_base  = b & 24'hFFFFFC;
    wr_snap   = wr_cnt;
    rd_snap   = rd_cnt;
    vld_snap  = vld_cycles;
    sb_snap   = sb_err;
    st_snap   = stall_seen;
    base_addr = b;
    nwords    = n;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    bit seen = 0;
    for (int k = 0; k < maxc; k++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] t1d [5];
    bit got;
    t1d = '{32'd0, 32'd12, 32'd24, 32'd36, 32'd48};
    rst = 1'b1; start = 1'b0; base_addr = '0; nwords = '0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check_eq("rst_valid", 64'(iob_valid), 64'd0);
    check_eq("rst_addr", 64'(iob_addr), 64'd0);
    check_eq("rst_wdata", 64'(iob_wdata), 64'd0);
    check_eq("rst_wstrb", 64'(iob_wstrb), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_pass", 64'(pass), 64'd0);
    check_eq("rst_err", 64'(err_cnt), 64'd0);
    check_eq("rst_first", 64'(first_err_addr), 64'd0);
    rst = 1'b0;

    // basic 5-word run
    start_test(24'h0, 8'd5);
    wait_done("t1", 200);
    check_eq("t1_pass", 64'(pass), 64'd1);
    check_eq("t1_err", 64'(err_cnt), 64'd0);
    check_eq("t1_first", 64'(first_err_addr), 64'd0);
    check_eq("t1_busy", 64'(busy), 64'd0);
    check_eq("t1_writes", 64'(wr_cnt - wr_snap), 64'd5);
    check_eq("t1_reads", 64'(rd_cnt - rd_snap), 64'd5);
    check_eq("t1_sb", 64'(sb_err - sb_snap), 64'd0);
    for (int i = 0; i < 5; i++) check_eq("t1_mem", 64'(rd_mem(24'(4 * i))), 64'(t1d[i]));
    @(posedge clk); #1;
    check_eq("t1_done_pulse", 64'(done), 64'd0);

    // corrupted word at address 8
    corrupt = 1;
    start_test(24'h0, 8'd5);
    wait_done("t2", 200);
    check_eq("t2_err", 64'(err_cnt), 64'd1);
    check_eq("t2_first", 64'(first_err_addr), 64'd8);
    check_eq("t2_pass", 64'(pass), 64'd0);
    corrupt = 0;

    // random ready stalls
    stall_mode = 1;
    start_test(24'h100, 8'd20);
    wait_done("t3", 2000);
    check_eq("t3_writes", 64'(wr_cnt - wr_snap), 64'd20);
    check_eq("t3_reads", 64'(rd_cnt - rd_snap), 64'd20);
    check_eq("t3_sb", 64'(sb_err - sb_snap), 64'd0);
    check_eq("t3_stall_stable", 64'(stall_err), 64'd0);
    check_eq("t3_stalls_seen", 64'(stall_seen > st_snap), 64'd1);
    check_eq("t3_pass", 64'(pass), 64'd1);
    check_eq("t3_err", 64'(err_cnt), 64'd0);
    stall_mode = 0;

    // zero words: done two edges after start is sampled
    start_test(24'h0, 8'd0);
    check_eq("t4_done_early", 64'(done), 64'd0);
    check_eq("t4_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check_eq("t4_done", 64'(done), 64'd1);
    check_eq("t4_pass", 64'(pass), 64'd1);
    check_eq("t4_busy_end", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check_eq("t4_done_pulse", 64'(done), 64'd0);
    check_eq("t4_no_valid", 64'(vld_cycles - vld_snap), 64'd0);

    // reset while a read is outstanding, then a stray rvalid
    no_resp = 1;
    start_test(24'h0, 8'd5);
    got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (iob_valid && iob_wstrb == 4'h0 && iob_ready) begin
        got = 1;
        break;
      end
    end
    check_eq("t5_read_req_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    check_eq("t5_wait_valid", 64'(iob_valid), 64'd0);
    check_eq("t5_wait_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("t5_rst_valid", 64'(iob_valid), 64'd0);
    check_eq("t5_rst_addr", 64'(iob_addr), 64'd0);
    check_eq("t5_rst_busy", 64'(busy), 64'd0);
    check_eq("t5_rst_done", 64'(done), 64'd0);
    check_eq("t5_rst_pass", 64'(pass), 64'd0);
    f_rdata  = 32'h0000_0BAD;
    f_rvalid = 1'b1;
    rst      = 1'b0;
    @(posedge clk); #1;
    f_rvalid = 1'b0;
    @(posedge clk); #1;
    check_eq("t5_stray_err", 64'(err_cnt), 64'd0);
    check_eq("t5_stray_first", 64'(first_err_addr), 64'd0);
    check_eq("t5_stray_busy", 64'(busy), 64'd0);
    no_resp = 0;
    start_test(24'h0, 8'd3);
    wait_done("t5b", 200);
    check_eq("t5b_pass", 64'(pass), 64'd1);
    check_eq("t5b_writes", 64'(wr_cnt - wr_snap), 64'd3);
    check_eq("t5b_sb", 64'(sb_err - sb_snap), 64'd0);

    // address wrap at top of space, with an ignored start while busy
    start_test(24'hFFFFF8, 8'd4);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t6_busy", 64'(busy), 64'd1);
    base_addr = 24'h40;
    nwords    = 8'd2;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t6", 300);
    check_eq("t6_writes", 64'(wr_cnt - wr_snap), 64'd4);
    check_eq("t6_reads", 64'(rd_cnt - rd_snap), 64'd4);
    check_eq("t6_sb", 64'(sb_err - sb_snap), 64'd0);
    check_eq("t6_pass", 64'(pass), 64'd1);
    check_eq("t6_err", 64'(err_cnt), 64'd0);
    check_eq("t6_mem_fff8", 64'(rd_mem(24'hFFFFF8)), 64'h2FF_FFE8);
    check_eq("t6_mem_fffc", 64'(rd_mem(24'hFFFFFC)), 64'h2FF_FFF4);
    check_eq("t6_mem_4", 64'(rd_mem(24'h000004)), 64'd12);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
